cyclic_encoder_7_4: RTL and testbench

Systematic (7,4) cyclic Hamming encoder with generator g(x)=x^3+x+1. It is the stage directly upstream of the serial (7,4) decoder. It accepts 4-bit messages over a valid/ready handshake and computes parity with a serial LFSR divider. It emits each 7-bit codeword serially, MSB (x^6) first, paced by the decoder's input-enable signal. An optional single-bit error injector lets benches exercise the decoder's correction path.

---
 rtl/hamming74_pkg.sv | 23 ++
 rtl/crc3_lfsr.sv | 32 +++
 rtl/cyclic_encoder_7_4.sv | 141 ++++++++++++++
 tb/tb_cyclic_encoder_7_4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// Shared (7,4) cyclic Hamming constants and types for the serial encoder/decoder pair.
package hamming74_pkg;

  localparam logic [3:0] G_POLY = 4'b1011;
  localparam int         N      = 7;
  localparam int         K      = 4;
  localparam int         NMK    = 3;

  // Syndrome seen by the decoder for an error in the first-sent bit (x^6).
  localparam logic [2:0] S6 = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    INFO,
    PARITY
  } enc_state_t;

  typedef enum logic {
    LFSR_DIVIDE,
    LFSR_SHIFT
  } lfsr_mode_t;

endpackage

// File: rtl/crc3_lfsr.sv
// Three-bit serial polynomial divider; in shift mode it drains the remainder MSB first.
module crc3_lfsr
  import hamming74_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  lfsr_mode_t mode,
  input  logic       din,
  output logic       r2
);

  logic [2:0] r;
  logic       fb;

  assign fb = din ^ r[2];
  assign r2 = r[2];

  // Draining shifts zeros in, so the register is clear again after the last parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 3'b000;
    end else if (shift_en) begin
      if (mode == LFSR_DIVIDE) begin
        r <= {r[1] ^ (fb & G_POLY[2]), r[0] ^ (fb & G_POLY[1]), fb & G_POLY[0]};
      end else begin
        r <= {r[1:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/cyclic_encoder_7_4.sv
// Systematic (7,4) cyclic encoder: one-entry message buffer, serializer FSM and optional bit injector.
module cyclic_encoder_7_4
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic             err_en,
  input  logic [2:0]       err_pos,
  output logic             data_out,
  output logic             code_valid,
  input  logic             dn_ready,
  output logic             word_done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [2:0] FIRST_POS     = 3'(N - 1);
  localparam logic [2:0] LAST_INFO_POS = 3'(N - K);

  enc_state_t state, next_state;

  logic       buf_full;
  logic [3:0] buf_msg;
  logic       buf_err_en;
  logic [2:0] buf_err_pos;

  logic [3:0] info_sh;
  logic       inj_en;
  logic [2:0] inj_pos;
  logic [2:0] pos;

  logic       accept;
  logic       xfer;
  logic       load;
  logic       true_bit;
  logic       lfsr_r2;
  lfsr_mode_t lfsr_mode;

  assign msg_ready  = !buf_full;
  assign accept     = msg_valid && msg_ready;
  assign code_valid = (state != IDLE);
  assign xfer       = code_valid && dn_ready;
  assign word_done  = xfer && (state == PARITY) && (pos == 3'd0);
  assign lfsr_mode  = (state == PARITY) ? LFSR_SHIFT : LFSR_DIVIDE;
  assign true_bit   = (state == PARITY) ? lfsr_r2 : info_sh[3];
  assign data_out   = code_valid && (true_bit ^ (inj_en && (inj_pos == pos)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          load       = 1'b1;
          next_state = INFO;
        end
      end
      INFO: begin
        if (xfer && pos == LAST_INFO_POS) begin
          next_state = PARITY;
        end
      end
      PARITY: begin
        if (word_done) begin
          if (buf_full) begin
            load       = 1'b1;
            next_state = INFO;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Accept only fills an empty buffer and load only drains a full one, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full    <= 1'b0;
      buf_msg     <= 4'd0;
      buf_err_en  <= 1'b0;
      buf_err_pos <= 3'd7;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_full    <= 1'b1;
      buf_msg     <= msg_in;
      buf_err_en  <= err_en;
      buf_err_pos <= err_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      info_sh <= 4'd0;
      inj_en  <= 1'b0;
      inj_pos <= 3'd7;
      pos     <= 3'd0;
    end else if (load) begin
      info_sh <= buf_msg;
      inj_en  <= buf_err_en;
      inj_pos <= buf_err_pos;
      pos     <= FIRST_POS;
    end else if (xfer) begin
      info_sh <= {info_sh[2:0], 1'b0};
      pos     <= pos - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (word_done) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // The divider always sees the uncorrupted info bit, so injected errors never leak into parity.
  crc3_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (xfer),
    .mode     (lfsr_mode),
    .din      (info_sh[3]),
    .r2       (lfsr_r2)
  );

endmodule

// File: tb/tb_cyclic_encoder_7_4.sv
// Directed bench for cyclic_encoder_7_4 with hand-computed codewords and immediate assertions.
module tb_cyclic_encoder_7_4;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       msg_in = 4'd0;
  logic             msg_valid = 1'b0;
  logic             msg_ready;
  logic             err_en = 1'b0;
  logic [2:0]       err_pos = 3'd7;
  logic             data_out;
  logic             code_valid;
  logic             dn_ready = 1'b0;
  logic             word_done;
  logic [CNT_W-1:0] word_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cyclic_encoder_7_4 #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_in     (msg_in),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .err_en     (err_en),
    .err_pos    (err_pos),
    .data_out   (data_out),
    .code_valid (code_valid),
    .dn_ready   (dn_ready),
    .word_done  (word_done),
    .word_cnt   (word_cnt)
  );

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    dn_ready  = 1'b0;
    err_en    = 1'b0;
    err_pos   = 3'd7;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic apply_stimulus(input logic [3:0] msg, input logic e_en, input logic [2:0] e_pos);
    bit taken = 1'b0;
    msg_in    = msg;
    err_en    = e_en;
    err_pos   = e_pos;
    msg_valid = 1'b1;
    for (int c = 0; c < 100 && !taken; c++) begin
      #1;
      if (msg_ready) taken = 1'b1;
      @(negedge clk);
    end
    msg_valid = 1'b0;
    err_en    = 1'b0;
    check_output("accept", 16'(taken), 16'd1);
  endtask

  // Called on a falling edge; receives bits 6 down to 7-nbits of exp, optionally stalling before each.
  task automatic recv_word(input string tag, input logic [6:0] exp, input int nbits,
                           input bit wait_first, input bit stall);
    bit seen;
    for (int i = 6; i > 6 - nbits; i--) begin
      if (i == 6 && wait_first) begin
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          #1;
          if (code_valid) seen = 1'b1;
          else @(negedge clk);
        end
      end else begin
        #1;
      end
      check_output($sformatf("%s_valid%0d", tag, i), 16'(code_valid), 16'd1);
      if (stall) begin
        dn_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          #1;
          check_output($sformatf("%s_hold%0d", tag, i), 16'(data_out), 16'(exp[i]));
          check_output($sformatf("%s_holdv%0d", tag, i), 16'(code_valid), 16'd1);
        end
      end
      dn_ready = 1'b1;
      #1;
      check_output($sformatf("%s_bit%0d", tag, i), 16'(data_out), 16'(exp[i]));
      check_output($sformatf("%s_done%0d", tag, i), 16'(word_done), 16'(i == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_output("rst_ready", 16'(msg_ready), 16'd1);
    check_output("rst_valid", 16'(code_valid), 16'd0);
    check_output("rst_data", 16'(data_out), 16'd0);
    check_output("rst_done", 16'(word_done), 16'd0);
    check_output("rst_cnt", 16'(word_cnt), 16'd0);

    // Single word, minimum latency
    apply_reset();
    apply_stimulus(4'b1000, 1'b0, 3'd7);
    #1;
    check_output("lat_not_yet", 16'(code_valid), 16'd0);
    @(negedge clk);
    recv_word("w1000", 7'b1000101, 7, 1'b0, 1'b0);
    #1;
    check_output("w1000_cnt", 16'(word_cnt), 16'd1);
    check_output("w1000_idle", 16'(code_valid), 16'd0);
    check_output("w1000_idle_data", 16'(data_out), 16'd0);
    @(negedge clk);

    // Back-to-back words
    apply_reset();
    fork
      begin
        apply_stimulus(4'b1101, 1'b0, 3'd7);
        apply_stimulus(4'b0001, 1'b0, 3'd7);
        apply_stimulus(4'b1111, 1'b0, 3'd7);
        apply_stimulus(4'b0000, 1'b0, 3'd7);
      end
      begin
        recv_word("b2b_1101", 7'b1101001, 7, 1'b1, 1'b0);
        recv_word("b2b_0001", 7'b0001011, 7, 1'b0, 1'b0);
        recv_word("b2b_1111", 7'b1111111, 7, 1'b0, 1'b0);
        recv_word("b2b_0000", 7'b0000000, 7, 1'b0, 1'b0);
      end
    join
    #1;
    check_output("b2b_cnt", 16'(word_cnt), 16'd4);
    check_output("b2b_idle", 16'(code_valid), 16'd0);
    @(negedge clk);

    // Stalled output with a second message parked in the buffer
    apply_reset();
    apply_stimulus(4'b1101, 1'b0, 3'd7);
    apply_stimulus(4'b0010, 1'b0, 3'd7);
    #1;
    check_output("stall_buf_full", 16'(msg_ready), 16'd0);
    @(negedge clk);
    recv_word("stall_1101", 7'b1101001, 7, 1'b1, 1'b1);
    recv_word("stall_0010", 7'b0010110, 7, 1'b0, 1'b0);
    #1;
    check_output("stall_cnt", 16'(word_cnt), 16'd2);
    @(negedge clk);

    // Error injection
    apply_reset();
    apply_stimulus(4'b1000, 1'b1, 3'd3);
    recv_word("inj_pos3", 7'b1001101, 7, 1'b1, 1'b0);
    apply_stimulus(4'b1000, 1'b1, 3'd7);
    recv_word("inj_pos7", 7'b1000101, 7, 1'b1, 1'b0);
    apply_stimulus(4'b0001, 1'b1, 3'd0);
    recv_word("inj_pos0", 7'b0001010, 7, 1'b1, 1'b0);
    #1;
    check_output("inj_cnt", 16'(word_cnt), 16'd3);
    @(negedge clk);

    // Reset in the middle of a word
    apply_reset();
    apply_stimulus(4'b1111, 1'b0, 3'd7);
    recv_word("abort_1111", 7'b1111111, 3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", 16'(code_valid), 16'd0);
    check_output("abort_data", 16'(data_out), 16'd0);
    check_output("abort_ready", 16'(msg_ready), 16'd1);
    check_output("abort_done", 16'(word_done), 16'd0);
    check_output("abort_cnt", 16'(word_cnt), 16'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    dn_ready = 1'b0;
    @(negedge clk);
    #1;
    check_output("abort_stays_idle", 16'(code_valid), 16'd0);
    @(negedge clk);
    apply_stimulus(4'b0001, 1'b0, 3'd7);
    #1;
    check_output("abort_cnt_before", 16'(word_cnt), 16'd0);
    @(negedge clk);
    recv_word("after_0001", 7'b0001011, 7, 1'b1, 1'b0);
    #1;
    check_output("after_cnt", 16'(word_cnt), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
